// File: rtl/grid_pkg.sv
// Shared constants for the radar polar-grid overlay: geometry, colours, spoke trig tables.
// Latency: n/a (package only).
// Backpressure: n/a.
package grid_pkg;

  localparam int RING_SPACING = 64;
  localparam int NUM_RINGS    = 4;
  localparam int RING_TOL     = 2;
  localparam int SPOKE_TOL    = 3;
  localparam int MIN_SPOKE_R  = 16;
  localparam int SPOKE_COUNT  = 7;
  localparam int R_MAX        = RING_SPACING * NUM_RINGS;

  localparam logic [23:0] RING_COLOR  = 24'h00FF00;
  localparam logic [23:0] SPOKE_COLOR = 24'h008000;

  // cos(15*t deg) * 1024, rounded; t = 0..6
  function automatic logic [10:0] cos_q10(input int t);
    case (t)
      0:       cos_q10 = 11'd1024;
      1:       cos_q10 = 11'd989;
      2:       cos_q10 = 11'd887;
      3:       cos_q10 = 11'd724;
      4:       cos_q10 = 11'd512;
      5:       cos_q10 = 11'd265;
      default: cos_q10 = 11'd0;
    endcase
  endfunction

  // sin(15*t deg) * 1024 is the cosine table read backwards
  function automatic logic [10:0] sin_q10(input int t);
    sin_q10 = cos_q10(SPOKE_COUNT - 1 - t);
  endfunction

endpackage

// File: rtl/grid_spoke_test.sv
// One bearing spoke: distance-to-line and along-line projection, then a thickness/near-origin test.
// Latency: 2 clocks (products registered, then hit registered).
// Backpressure: none; accepts one pixel every clock.
module grid_spoke_test
  import grid_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [12:0] i_ax,
  input  logic [11:0] i_y,
  input  logic [10:0] i_c,
  input  logic [10:0] i_s,
  output logic        o_hit
);

  localparam logic signed [24:0] D_TOL = 25'(SPOKE_TOL * 1024);
  localparam logic signed [24:0] P_MIN = 25'(MIN_SPOKE_R * 1024);

  logic signed [24:0] w_ax, w_y, w_c, w_s, w_d, w_p;
  logic signed [24:0] r_d, r_p;
  logic               r_hit;

  // Everything widened to 25-bit signed so the sums cannot overflow for any 12-bit input
  assign w_ax = $signed({12'd0, i_ax});
  assign w_y  = $signed({{13{i_y[11]}}, i_y});
  assign w_c  = $signed({14'd0, i_c});
  assign w_s  = $signed({14'd0, i_s});
  assign w_d  = w_ax * w_c - w_y * w_s;
  assign w_p  = w_ax * w_s + w_y * w_c;

  // Stage 1: capture perpendicular distance and projection (both scaled by 1024)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_d <= '0;
      r_p <= '0;
    end else begin
      r_d <= w_d;
      r_p <= w_p;
    end
  end

  // Stage 2: inside the spoke's band and far enough from the origin
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_hit <= 1'b0;
    end else begin
      r_hit <= (r_d >= -D_TOL) && (r_d <= D_TOL) && (r_p >= P_MIN);
    end
  end

  assign o_hit = r_hit;

endmodule

// File: rtl/grid_overlay.sv
// Polar grid overlay: range rings and mirrored bearing spokes over the forward half-plane.
// Latency: 2 clocks, fully pipelined.
// Backpressure: none; a new pixel every clock is accepted.
module grid_overlay
  import grid_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  output logic [23:0] pixel
);

  localparam logic [23:0] RMAX_SQ = 24'(R_MAX * R_MAX);

  logic [12:0]            w_xs, w_ys, w_ax, w_ay;
  logic [23:0]            w_r2;
  logic [NUM_RINGS-1:0]   w_ring;
  logic [SPOKE_COUNT-1:0] w_hit;

  logic [23:0] r_r2;
  logic        r_y_neg;
  logic        r_ring;
  logic        r_spoke_ok;

  // 13-bit magnitudes so -2048 becomes +2048 without wrapping
  assign w_xs = {x_value[11], x_value};
  assign w_ys = {y_value[11], y_value};
  assign w_ax = w_xs[12] ? (~w_xs + 13'd1) : w_xs;
  assign w_ay = w_ys[12] ? (~w_ys + 13'd1) : w_ys;
  assign w_r2 = 24'(w_ax) * 24'(w_ax) + 24'(w_ay) * 24'(w_ay);

  // Stage 1: squared radius and half-plane flag
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_r2    <= '0;
      r_y_neg <= 1'b0;
    end else begin
      r_r2    <= w_r2;
      r_y_neg <= y_value[11];
    end
  end

  // Ring k band: R^2 - 2*R*TOL <= r2 <= R^2 + 2*R*TOL, avoiding any square root
  for (genvar k = 0; k < NUM_RINGS; k++) begin : g_ring
    localparam int          R  = RING_SPACING * (k + 1);
    localparam logic [23:0] LO = 24'(R * R - 2 * R * RING_TOL);
    localparam logic [23:0] HI = 24'(R * R + 2 * R * RING_TOL);
    assign w_ring[k] = (r_r2 >= LO) && (r_r2 <= HI);
  end

  // Spokes take |x| so each test covers both the +t and -t bearing
  for (genvar t = 0; t < SPOKE_COUNT; t++) begin : g_spoke
    grid_spoke_test u_spoke (
      .clock   (clock),
      .reset_n (reset_n),
      .i_ax    (w_ax),
      .i_y     (y_value),
      .i_c     (cos_q10(t)),
      .i_s     (sin_q10(t)),
      .o_hit   (w_hit[t])
    );
  end

  // Stage 2: ring classification and spoke gating, aligned with the spoke hit registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ring     <= 1'b0;
      r_spoke_ok <= 1'b0;
    end else begin
      r_ring     <= !r_y_neg && (|w_ring);
      r_spoke_ok <= !r_y_neg && (r_r2 <= RMAX_SQ);
    end
  end

  // Rings win over spokes; all inputs here are registers so reset clears pixel at once
  assign pixel = r_ring                     ? RING_COLOR  :
                 (r_spoke_ok && (|w_hit))   ? SPOKE_COLOR : 24'h000000;

endmodule

// File: tb/tb_grid_overlay.sv
module tb_grid_overlay;

  logic        clock;
  logic        reset_n;
  logic [11:0] x_value;
  logic [11:0] y_value;
  logic [23:0] pixel;

  int total = 0;
  int bad   = 0;

  logic [23:0] exp1 = 24'h0;
  logic [23:0] exp2 = 24'h0;

  int cos_tab [7] = '{1024, 989, 887, 724, 512, 265, 0};
  int sin_tab [7] = '{0, 265, 512, 724, 887, 989, 1024};

  int dir_x [12] = '{0, 23, 50, -50, 100, 0, 300, 40, 70, -2048, 2047, -2048};
  int dir_y [12] = '{128, 254, 178, 178, 100, 0, 0, -100, 120, 0, 2047, -2048};

  grid_overlay dut (
    .clock   (clock),
    .reset_n (reset_n),
    .x_value (x_value),
    .y_value (y_value),
    .pixel   (pixel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference: evaluate the geometric rules directly on integers
  function automatic logic [23:0] ref_pixel(input int x, input int y);
    int ax, r2, d, p, rr;
    ax = iabs(x);
    r2 = x * x + y * y;
    if (y < 0) return 24'h0;
    for (int k = 1; k <= 4; k++) begin
      rr = 64 * k;
      if (iabs(r2 - rr * rr) <= 2 * rr * 2) return 24'h00FF00;
    end
    if (r2 > 256 * 256) return 24'h0;
    for (int t = 0; t < 7; t++) begin
      d = ax * cos_tab[t] - y * sin_tab[t];
      p = ax * sin_tab[t] + y * cos_tab[t];
      if (iabs(d) <= 3 * 1024 && p >= 16 * 1024) return 24'h008000;
    end
    return 24'h0;
  endfunction

  // Apply one pixel, advance one clock, check the output for the pixel from 2 clocks back
  task automatic cycle(input int x, input int y, input string tag);
    x_value = 12'(x);
    y_value = 12'(y);
    @(posedge clock);
    if (!reset_n) begin
      exp1 = 24'h0;
      exp2 = 24'h0;
    end else begin
      exp2 = exp1;
      exp1 = ref_pixel(x, y);
    end
    @(negedge clock);
    total++;
    assert (pixel === exp2) else begin
      bad++;
      $error("FAIL %s x=%0d y=%0d pixel=%h expected=%h", tag, x, y, pixel, exp2);
    end
  endtask

  initial begin
    int rx, ry;
    reset_n = 1'b0;
    x_value = 12'd0;
    y_value = 12'd0;
    #1;
    total++;
    assert (pixel === 24'h0) else begin
      bad++;
      $error("FAIL reset_state pixel=%h expected=000000", pixel);
    end

    repeat (2) cycle(100, 100, "in_reset");
    reset_n = 1'b1;

    // Directed vectors streamed back to back, then two flush cycles
    for (int i = 0; i < 12; i++) cycle(dir_x[i], dir_y[i], "directed");
    cycle(0, 0, "flush");
    cycle(0, 0, "flush");

    // Stream again, then drop reset mid-stream
    for (int i = 0; i < 5; i++) cycle(dir_x[i], dir_y[i], "pre_reset");
    #2 reset_n = 1'b0;
    #1;
    total++;
    assert (pixel === 24'h0) else begin
      bad++;
      $error("FAIL async_reset pixel=%h expected=000000", pixel);
    end
    @(negedge clock);
    cycle(0, 128, "during_reset");
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) cycle(dir_x[i], dir_y[i], "post_reset");

    // Random pixels concentrated on the grid area
    for (int i = 0; i < 400; i++) begin
      rx = int'($urandom_range(0, 640)) - 320;
      ry = int'($urandom_range(0, 360)) - 40;
      cycle(rx, ry, "rand_grid");
    end
    // Random pixels over the full coordinate range
    for (int i = 0; i < 100; i++) begin
      rx = int'($urandom_range(0, 4095)) - 2048;
      ry = int'($urandom_range(0, 4095)) - 2048;
      cycle(rx, ry, "rand_full");
    end
    cycle(0, 0, "flush");
    cycle(0, 0, "flush");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
